// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CPU execution controller: host commands, run states
// and halt causes, plus the command-legality rule used for cmd_err.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_NOP       = 3'd0,
        OP_RUN       = 3'd1,
        OP_HALT      = 3'd2,
        OP_STEP      = 3'd3,
        OP_SET_BP    = 3'd4,
        OP_CLR_BP    = 3'd5,
        OP_RESET_CPU = 3'd6
    } cmd_op_t;

    typedef enum logic [1:0] {
        ST_HALTED    = 2'd0,
        ST_RUN       = 2'd1,
        ST_STEP      = 2'd2,
        ST_RESETTING = 2'd3
    } run_state_t;

    typedef enum logic [2:0] {
        CAUSE_NONE       = 3'd0,
        CAUSE_HOST       = 3'd1,
        CAUSE_STEP_DONE  = 3'd2,
        CAUSE_BREAKPOINT = 3'd3,
        CAUSE_HALT_INSTR = 3'd4
    } halt_cause_t;

    // JMP with zero offset: a self-loop the core would otherwise spin on forever.
    localparam logic [15:0] DEFAULT_HALT_INSTR = 16'h9000;

    function automatic logic is_legal_cmd(input run_state_t st, input logic [2:0] op);
        logic ok;
        ok = 1'b0;
        case (st)
            ST_HALTED: ok = (op != 3'd7);
            ST_RUN, ST_STEP: ok = (op == OP_NOP) || (op == OP_HALT) ||
                                  (op == OP_SET_BP) || (op == OP_CLR_BP);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/cpu_bp_unit.sv
// Single hardware PC breakpoint with a one-shot skip so a resume from the
// breakpoint address can execute the instruction it stopped on.
module cpu_bp_unit #(
    parameter int PC_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                set_bp,
    input  logic                clr_bp,
    input  logic [PC_WIDTH-1:0] set_addr,
    input  logic                arm_skip,
    input  logic                active,
    input  logic [PC_WIDTH-1:0] pc,
    output logic                bp_match
);

    logic                bp_valid;
    logic [PC_WIDTH-1:0] bp_addr;
    logic                skip_bp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bp_valid <= 1'b0;
            bp_addr  <= '0;
            skip_bp  <= 1'b0;
        end else begin
            if (set_bp) begin
                bp_addr  <= set_addr;
                bp_valid <= 1'b1;
            end else if (clr_bp) begin
                bp_valid <= 1'b0;
            end
            // Skip covers only the first executing cycle after a RUN/STEP start.
            if (arm_skip) begin
                skip_bp <= 1'b1;
            end else if (active) begin
                skip_bp <= 1'b0;
            end
        end
    end

    assign bp_match = bp_valid && (pc == bp_addr) && !skip_bp;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Execution controller for the single-cycle 16-bit core: run/halt/step,
// breakpoint and halt-instruction stops, core reset sequencing, retire count.
module cpu_run_ctrl import cpu_ctrl_pkg::*; #(
    parameter int                     PC_WIDTH    = 16,
    parameter int                     INSTR_WIDTH = 16,
    parameter int                     CNT_WIDTH   = 32,
    parameter logic [INSTR_WIDTH-1:0] HALT_INSTR  = INSTR_WIDTH'(DEFAULT_HALT_INSTR),
    parameter int                     RST_CYCLES  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_op,
    input  logic [15:0]            cmd_arg,
    output logic                   cmd_err,
    input  logic [PC_WIDTH-1:0]    pc_current,
    input  logic [INSTR_WIDTH-1:0] instruction,
    output logic                   cpu_en,
    output logic                   cpu_rst,
    output logic [1:0]             state,
    output logic [2:0]             halt_cause,
    output logic                   bp_hit,
    output logic [CNT_WIDTH-1:0]   retired
);

    localparam int RC_W = (RST_CYCLES < 1) ? 1 : $clog2(RST_CYCLES + 1);

    run_state_t   state_q;
    halt_cause_t  cause_q;
    logic [15:0]  step_rem;
    logic [RC_W-1:0] rst_cnt;

    logic cmd_fire, active, halt_hit, bp_match, stop_now;
    logic start_run, start_step, host_halt;

    // Handshake: a command transfers on a clock edge where cmd_valid && cmd_ready;
    // the host holds cmd_op/cmd_arg stable while cmd_valid is high and not yet accepted.
    assign cmd_ready  = (state_q != ST_RESETTING);
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign active     = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign halt_hit   = (instruction == HALT_INSTR);
    assign stop_now   = active && (bp_match || halt_hit);
    assign cpu_en     = active && !stop_now;
    assign cpu_rst    = rst || (state_q == ST_RESETTING);
    assign start_run  = cmd_fire && (state_q == ST_HALTED) && (cmd_op == OP_RUN);
    assign start_step = cmd_fire && (state_q == ST_HALTED) && (cmd_op == OP_STEP);
    assign host_halt  = cmd_fire && (cmd_op == OP_HALT);
    assign state      = state_q;
    assign halt_cause = cause_q;

    cpu_bp_unit #(.PC_WIDTH(PC_WIDTH)) u_bp (
        .clk      (clk),
        .rst      (rst),
        .set_bp   (cmd_fire && (cmd_op == OP_SET_BP)),
        .clr_bp   (cmd_fire && (cmd_op == OP_CLR_BP)),
        .set_addr (cmd_arg[PC_WIDTH-1:0]),
        .arm_skip (start_run || start_step),
        .active   (active),
        .pc       (pc_current),
        .bp_match (bp_match)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_HALTED;
            cause_q  <= CAUSE_NONE;
            step_rem <= '0;
            rst_cnt  <= '0;
            retired  <= '0;
            cmd_err  <= 1'b0;
            bp_hit   <= 1'b0;
        end else begin
            cmd_err <= cmd_fire && !is_legal_cmd(state_q, cmd_op);
            bp_hit  <= 1'b0;
            if (cpu_en) begin
                retired <= retired + CNT_WIDTH'(1);
            end
            case (state_q)
                ST_HALTED: begin
                    if (start_run) begin
                        state_q <= ST_RUN;
                        cause_q <= CAUSE_NONE;
                    end else if (start_step) begin
                        state_q  <= ST_STEP;
                        cause_q  <= CAUSE_NONE;
                        step_rem <= (cmd_arg == 16'd0) ? 16'd1 : cmd_arg;
                    end else if (cmd_fire && (cmd_op == OP_RESET_CPU)) begin
                        state_q <= ST_RESETTING;
                        cause_q <= CAUSE_NONE;
                        rst_cnt <= RC_W'(RST_CYCLES);
                        retired <= '0;
                    end
                end
                ST_RUN, ST_STEP: begin
                    if (cpu_en && (state_q == ST_STEP)) begin
                        step_rem <= step_rem - 16'd1;
                    end
                    // Stop causes are checked in priority order; a stop_now cause beats a host HALT.
                    if (stop_now) begin
                        state_q <= ST_HALTED;
                        cause_q <= bp_match ? CAUSE_BREAKPOINT : CAUSE_HALT_INSTR;
                        bp_hit  <= bp_match;
                    end else if (host_halt) begin
                        state_q <= ST_HALTED;
                        cause_q <= CAUSE_HOST;
                    end else if ((state_q == ST_STEP) && (step_rem == 16'd1)) begin
                        state_q <= ST_HALTED;
                        cause_q <= CAUSE_STEP_DONE;
                    end
                end
                ST_RESETTING: begin
                    if (rst_cnt <= RC_W'(1)) begin
                        state_q <= ST_HALTED;
                        cause_q <= CAUSE_NONE;
                        rst_cnt <= '0;
                    end else begin
                        rst_cnt <= rst_cnt - RC_W'(1);
                    end
                end
                default: state_q <= ST_HALTED;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: a tiny core model (PC counter plus one
// halt-instruction location) driven by the controller, checked against hand-computed vectors.
module tb_cpu_run_ctrl;

    localparam logic [2:0] C_NOP = 3'd0, C_RUN = 3'd1, C_HALT = 3'd2, C_STEP = 3'd3,
                           C_SET_BP = 3'd4, C_CLR_BP = 3'd5, C_RESET_CPU = 3'd6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [15:0] cmd_arg = 16'd0;
    logic        cmd_err;
    logic [15:0] pc_current = 16'd0;
    logic [15:0] instruction;
    logic        cpu_en;
    logic        cpu_rst;
    logic [1:0]  state;
    logic [2:0]  halt_cause;
    logic        bp_hit;
    logic [31:0] retired;
    logic [15:0] halt_pc = 16'hFFFF;

    int total = 0;
    int bad   = 0;
    int n_en, n_bp, n_err, n_rst, n_nrdy;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] arg;
        logic [15:0] hpc;
        int          waitc;
        logic [1:0]  st;
        logic [2:0]  cause;
        logic [15:0] pc;
        logic [31:0] ret;
        int          en;
        int          bp;
        int          err;
        int          rstc;
    } vec_t;

    vec_t vecs[10];

    cpu_run_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_arg     (cmd_arg),
        .cmd_err     (cmd_err),
        .pc_current  (pc_current),
        .instruction (instruction),
        .cpu_en      (cpu_en),
        .cpu_rst     (cpu_rst),
        .state       (state),
        .halt_cause  (halt_cause),
        .bp_hit      (bp_hit),
        .retired     (retired)
    );

    // Clock and core model: PC advances on cpu_en, returns to 0 under cpu_rst.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cpu_rst) pc_current <= 16'd0;
        else if (cpu_en) pc_current <= pc_current + 16'd1;
    end

    assign instruction = (pc_current == halt_pc) ? 16'h9000 : 16'h1234;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_cmd(input logic [2:0] op, input logic [15:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
    endtask

    task automatic idle_cmd();
        cmd_valid = 1'b0;
        cmd_op    = C_NOP;
        cmd_arg   = 16'd0;
    endtask

    task automatic sample_counts();
        if (cpu_en)     n_en++;
        if (bp_hit)     n_bp++;
        if (cmd_err)    n_err++;
        if (cpu_rst)    n_rst++;
        if (!cmd_ready) n_nrdy++;
    endtask

    initial begin
        //          op           arg     hpc      wait st cause pc  ret en bp err rstc
        vecs[0] = '{C_STEP,      16'd3,  16'hFFFF, 8,  0, 2,   3,  3,  3, 0, 0, 0};
        vecs[1] = '{C_SET_BP,    16'd5,  16'hFFFF, 2,  0, 2,   3,  3,  0, 0, 0, 0};
        vecs[2] = '{C_RESET_CPU, 16'd0,  16'hFFFF, 5,  0, 0,   0,  0,  0, 0, 0, 2};
        vecs[3] = '{C_RUN,       16'd0,  16'hFFFF, 12, 0, 3,   5,  5,  5, 1, 0, 0};
        vecs[4] = '{C_SET_BP,    16'd7,  16'd7,    2,  0, 3,   5,  5,  0, 0, 0, 0};
        vecs[5] = '{C_RUN,       16'd0,  16'd7,    10, 0, 3,   7,  7,  2, 1, 0, 0};
        vecs[6] = '{C_CLR_BP,    16'd0,  16'd7,    2,  0, 3,   7,  7,  0, 0, 0, 0};
        vecs[7] = '{C_RUN,       16'd0,  16'd7,    5,  0, 4,   7,  7,  0, 0, 0, 0};
        vecs[8] = '{C_STEP,      16'd0,  16'hFFFF, 6,  0, 2,   8,  8,  1, 0, 0, 0};
        vecs[9] = '{C_HALT,      16'd0,  16'hFFFF, 2,  0, 2,   8,  8,  0, 0, 0, 0};

        // Reset values while rst is held.
        repeat (3) @(negedge clk);
        check("rst_state",   32'(state), 32'd0);
        check("rst_cause",   32'(halt_cause), 32'd0);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_cpu_en",  32'(cpu_en), 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_ready",   32'(cmd_ready), 32'd1);
        check("rst_bp_hit",  32'(bp_hit), 32'd0);
        check("rst_cmd_err", 32'(cmd_err), 32'd0);
        rst = 1'b0;
        #1;
        check("rel_cpu_rst", 32'(cpu_rst), 32'd0);

        // Table-driven command vectors: issue, let it settle, compare.
        for (int v = 0; v < 10; v++) begin
            n_en = 0; n_bp = 0; n_err = 0; n_rst = 0; n_nrdy = 0;
            for (int c = 0; c <= vecs[v].waitc; c++) begin
                @(negedge clk);
                if (c == 0) begin
                    halt_pc = vecs[v].hpc;
                    drive_cmd(vecs[v].op, vecs[v].arg);
                end else begin
                    sample_counts();
                    idle_cmd();
                end
            end
            check($sformatf("v%0d_state", v),   32'(state), 32'(vecs[v].st));
            check($sformatf("v%0d_cause", v),   32'(halt_cause), 32'(vecs[v].cause));
            check($sformatf("v%0d_pc", v),      32'(pc_current), 32'(vecs[v].pc));
            check($sformatf("v%0d_retired", v), retired, vecs[v].ret);
            check($sformatf("v%0d_en_cyc", v),  n_en, vecs[v].en);
            check($sformatf("v%0d_bp_hit", v),  n_bp, vecs[v].bp);
            check($sformatf("v%0d_cmd_err", v), n_err, vecs[v].err);
            check($sformatf("v%0d_rst_cyc", v), n_rst, vecs[v].rstc);
            check($sformatf("v%0d_nrdy_cyc", v), n_nrdy, vecs[v].rstc);
        end

        // RUN, then STEP while running (rejected), then HALT: pc 8 -> 10.
        @(negedge clk); drive_cmd(C_RUN, 16'd0);
        @(negedge clk); drive_cmd(C_STEP, 16'd4);
        check("seq_run_state", 32'(state), 32'd1);
        check("seq_run_err0",  32'(cmd_err), 32'd0);
        @(negedge clk); drive_cmd(C_HALT, 16'd0);
        check("seq_step_err",   32'(cmd_err), 32'd1);
        check("seq_step_state", 32'(state), 32'd1);
        @(negedge clk); idle_cmd();
        check("seq_halt_state", 32'(state), 32'd0);
        check("seq_halt_cause", 32'(halt_cause), 32'd1);
        check("seq_err_clear",  32'(cmd_err), 32'd0);
        check("seq_halt_en",    32'(cpu_en), 32'd0);
        check("seq_halt_pc",    32'(pc_current), 32'd10);
        check("seq_halt_ret",   retired, 32'd10);

        // Breakpoint at 3, STEP 10, then asynchronous rst in the middle of it.
        @(negedge clk); drive_cmd(C_SET_BP, 16'd3);
        @(negedge clk); drive_cmd(C_STEP, 16'd10);
        @(negedge clk); idle_cmd();
        check("mid_step_state", 32'(state), 32'd2);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_state",   32'(state), 32'd0);
        check("arst_cause",   32'(halt_cause), 32'd0);
        check("arst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("arst_cpu_en",  32'(cpu_en), 32'd0);
        check("arst_retired", retired, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n_en = 0;
        repeat (4) begin
            @(negedge clk);
            if (cpu_en) n_en++;
        end
        check("post_rst_en", n_en, 32'd0);
        check("post_rst_pc", 32'(pc_current), 32'd0);

        // RUN past address 3: the breakpoint must be gone after rst.
        @(negedge clk); drive_cmd(C_RUN, 16'd0);
        @(negedge clk); idle_cmd();
        repeat (3) @(negedge clk);
        @(negedge clk); drive_cmd(C_HALT, 16'd0);
        @(negedge clk); idle_cmd();
        check("bpclr_state", 32'(state), 32'd0);
        check("bpclr_cause", 32'(halt_cause), 32'd1);
        check("bpclr_pc",    32'(pc_current), 32'd5);
        check("bpclr_ret",   retired, 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
